// File: rtl/rvfi_bus_dmem_fault_region_check_if.sv
// Bus/RVFI signal bundle observed by the dmem fault-region checker.
// The environment drives it through the master modport; the checker only listens.
interface rvfi_bus_dmem_if #(
    parameter int XLEN   = 32,
    parameter int BUSLEN = 32,
    parameter int NBUS   = 1,
    parameter int NRET   = 1
);
    logic                     check;
    logic [XLEN-1:0]          dmem_addr;
    logic [NRET-1:0]          rvfi_valid;
    logic [NRET-1:0]          rvfi_trap;
    logic [NRET-1:0]          rvfi_mem_fault;
    logic [NRET*XLEN-1:0]     rvfi_mem_addr;
    logic [NRET*XLEN/8-1:0]   rvfi_mem_rmask;
    logic [NRET*XLEN/8-1:0]   rvfi_mem_wmask;
    logic [NRET*XLEN-1:0]     rvfi_csr_mcause_wmask;
    logic [NRET*XLEN-1:0]     rvfi_csr_mcause_wdata;
    logic [NBUS-1:0]          rvfi_bus_valid;
    logic [NBUS-1:0]          rvfi_bus_data;
    logic [NBUS-1:0]          rvfi_bus_fault;
    logic [NBUS*XLEN-1:0]     rvfi_bus_addr;
    logic [NBUS*BUSLEN/8-1:0] rvfi_bus_rmask;
    logic [NBUS*BUSLEN/8-1:0] rvfi_bus_wmask;

    modport master (
        output check, dmem_addr, rvfi_valid, rvfi_trap, rvfi_mem_fault, rvfi_mem_addr,
               rvfi_mem_rmask, rvfi_mem_wmask, rvfi_csr_mcause_wmask, rvfi_csr_mcause_wdata,
               rvfi_bus_valid, rvfi_bus_data, rvfi_bus_fault, rvfi_bus_addr,
               rvfi_bus_rmask, rvfi_bus_wmask
    );

    modport slave (
        input  check, dmem_addr, rvfi_valid, rvfi_trap, rvfi_mem_fault, rvfi_mem_addr,
               rvfi_mem_rmask, rvfi_mem_wmask, rvfi_csr_mcause_wmask, rvfi_csr_mcause_wdata,
               rvfi_bus_valid, rvfi_bus_data, rvfi_bus_fault, rvfi_bus_addr,
               rvfi_bus_rmask, rvfi_bus_wmask
    );
endinterface

// File: rtl/rvfi_bus_dmem_fault_region_check.sv
// Checker forcing a dmem byte region to fault on the bus: every retired access to it must trap
// with the right cause, and a trapping retirement must follow a bus fault within MAX_LAT cycles.
module rvfi_bus_dmem_fault_region_check #(
    parameter int XLEN          = 32,
    parameter int BUSLEN        = 32,
    parameter int NBUS          = 1,
    parameter int NRET          = 1,
    parameter int REGION_BYTES  = 4,
    parameter int FAULT_MODE    = 3,
    parameter int MAX_LAT       = 16,
    parameter int CHAN_IDX      = -1,
    parameter int HAS_MEM_FAULT = 0,
    parameter int HAS_MCAUSE    = 0
) (
    input  logic            clock,
    input  logic            reset,
    rvfi_bus_dmem_if.slave  bus,
    output logic            env_violation,
    output logic            err_trap,
    output logic            err_cause,
    output logic            err_timeout,
    output logic            pending,
    output logic [15:0]     hit_count
);
    localparam int RB = XLEN / 8;
    localparam int BB = BUSLEN / 8;
    localparam int CNT_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [XLEN-1:0]  REGION_MASK = ~(XLEN'(REGION_BYTES - 1));
    localparam logic             MODE_RD     = ((FAULT_MODE % 2) == 1);
    localparam logic             MODE_WR     = (((FAULT_MODE / 2) % 2) == 1);
    localparam logic             TIMEOUT_EN  = (MAX_LAT > 0);
    localparam logic [CNT_W-1:0] LAT_LAST    = CNT_W'((MAX_LAT > 0) ? (MAX_LAT - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pending_q;
    logic             err_timeout_q;
    logic             env_q;
    logic             err_trap_q;
    logic             err_cause_q;
    logic [15:0]      hit_count_q;
    logic [15:0]      hit_count_d;

    logic             viol_s;
    logic             fault_ev_s;
    logic             hit_any_s;
    logic             trap_bad_s;
    logic             cause_bad_s;
    logic [15:0]      nhits_s;
    logic [16:0]      sum_s;

    function automatic logic in_region(input logic [XLEN-1:0] a, input logic [XLEN-1:0] base);
        return (a & REGION_MASK) == (base & REGION_MASK);
    endfunction

    // Bus side: classify every region byte in a faulting direction as faulted or unfaulted
    always_comb begin
        logic [XLEN-1:0] addr_v;
        logic            rel_v;
        addr_v     = '0;
        rel_v      = 1'b0;
        viol_s     = 1'b0;
        fault_ev_s = 1'b0;
        for (int b = 0; b < NBUS; b++) begin
            for (int k = 0; k < BB; k++) begin
                addr_v = bus.rvfi_bus_addr[b*XLEN +: XLEN] + XLEN'(k);
                rel_v  = bus.rvfi_bus_valid[b] & bus.rvfi_bus_data[b] & in_region(addr_v, bus.dmem_addr)
                       & ((bus.rvfi_bus_rmask[b*BB+k] & MODE_RD) | (bus.rvfi_bus_wmask[b*BB+k] & MODE_WR));
                fault_ev_s = fault_ev_s | (rel_v & bus.rvfi_bus_fault[b]);
                viol_s     = viol_s | (rel_v & ~bus.rvfi_bus_fault[b]);
            end
        end
    end

    // Retire side: detect hits and judge trap/cause; a store byte in the region selects code 7
    always_comb begin
        logic [XLEN-1:0] addr_v;
        logic            in_v;
        logic            touch_v;
        logic            wr_v;
        logic            hit_v;
        logic            trap_ok_v;
        logic            cause_ok_v;
        logic [XLEN-1:0] code_v;
        addr_v      = '0;
        in_v        = 1'b0;
        touch_v     = 1'b0;
        wr_v        = 1'b0;
        hit_v       = 1'b0;
        trap_ok_v   = 1'b0;
        cause_ok_v  = 1'b0;
        code_v      = '0;
        hit_any_s   = 1'b0;
        trap_bad_s  = 1'b0;
        cause_bad_s = 1'b0;
        nhits_s     = 16'd0;
        for (int c = 0; c < NRET; c++) begin
            touch_v = 1'b0;
            wr_v    = 1'b0;
            for (int j = 0; j < RB; j++) begin
                addr_v  = bus.rvfi_mem_addr[c*XLEN +: XLEN] + XLEN'(j);
                in_v    = in_region(addr_v, bus.dmem_addr);
                touch_v = touch_v | (in_v & ((bus.rvfi_mem_rmask[c*RB+j] & MODE_RD)
                                           | (bus.rvfi_mem_wmask[c*RB+j] & MODE_WR)));
                wr_v    = wr_v | (in_v & bus.rvfi_mem_wmask[c*RB+j] & MODE_WR);
            end
            hit_v      = ((CHAN_IDX < 0) || (c == CHAN_IDX)) & bus.check & bus.rvfi_valid[c] & touch_v;
            trap_ok_v  = bus.rvfi_trap[c] & (bus.rvfi_mem_fault[c] | (HAS_MEM_FAULT == 0));
            code_v     = wr_v ? XLEN'(7) : XLEN'(5);
            cause_ok_v = (HAS_MCAUSE == 0)
                       | ((bus.rvfi_csr_mcause_wmask[c*XLEN +: XLEN] == {XLEN{1'b1}})
                        & (bus.rvfi_csr_mcause_wdata[c*XLEN +: XLEN] == code_v));
            hit_any_s   = hit_any_s | hit_v;
            trap_bad_s  = trap_bad_s | (hit_v & ~trap_ok_v);
            cause_bad_s = cause_bad_s | (hit_v & ~cause_ok_v);
            nhits_s     = nhits_s + 16'(hit_v);
        end
    end

    // Saturating hit counter next value
    always_comb begin
        sum_s       = {1'b0, hit_count_q} + {1'b0, nhits_s};
        hit_count_d = sum_s[16] ? 16'hFFFF : sum_s[15:0];
    end

    // Sticky error flags and hit counter
    always_ff @(posedge clock) begin
        if (!reset) begin
            env_q       <= 1'b0;
            err_trap_q  <= 1'b0;
            err_cause_q <= 1'b0;
            hit_count_q <= 16'd0;
        end else begin
            env_q       <= env_q | viol_s;
            err_trap_q  <= err_trap_q | trap_bad_s;
            err_cause_q <= err_cause_q | cause_bad_s;
            hit_count_q <= hit_count_d;
        end
    end

    // Latency FSM: a bus fault opens a window that a trapping hit must close before MAX_LAT
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            pending_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fault_ev_s && !hit_any_s) begin
                        state_q   <= ST_PENDING;
                        cnt_q     <= '0;
                        pending_q <= 1'b1;
                    end else begin
                        state_q   <= ST_IDLE;
                        pending_q <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    if (hit_any_s) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        pending_q <= 1'b0;
                    end else if (TIMEOUT_EN && (cnt_q == LAT_LAST)) begin
                        state_q       <= ST_TIMEOUT;
                        pending_q     <= 1'b0;
                        err_timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_TIMEOUT: begin
                    state_q   <= ST_TIMEOUT;
                    pending_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign env_violation = env_q;
    assign err_trap      = err_trap_q;
    assign err_cause     = err_cause_q;
    assign err_timeout   = err_timeout_q;
    assign pending       = pending_q;
    assign hit_count     = hit_count_q;

`ifdef FORMAL
    env_ok: assume property (@(posedge clock) disable iff (!reset) !viol_s);
    no_err: assert property (@(posedge clock) !(err_trap_q || err_cause_q || err_timeout_q));
    hit_ok: cover property (@(posedge clock) disable iff (!reset) hit_any_s && !trap_bad_s && !cause_bad_s);
`endif
endmodule

// File: tb/tb_rvfi_bus_dmem_fault_region_check.sv
// Bench for the dmem fault-region checker: two parameterisations share one stimulus stream and
// are compared every cycle against a region/latency reference model.
module tb_rvfi_bus_dmem_fault_region_check;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    rvfi_bus_dmem_if bif ();

    logic [1:0]  env_v, trap_v, cause_v, to_v, pend_v;
    logic [15:0] hc_a, hc_b;

    rvfi_bus_dmem_fault_region_check #(.FAULT_MODE(3), .MAX_LAT(4), .HAS_MCAUSE(1)) u_dut_a (
        .clock(clock), .reset(reset), .bus(bif),
        .env_violation(env_v[0]), .err_trap(trap_v[0]), .err_cause(cause_v[0]),
        .err_timeout(to_v[0]), .pending(pend_v[0]), .hit_count(hc_a)
    );

    rvfi_bus_dmem_fault_region_check #(.FAULT_MODE(1), .MAX_LAT(16), .HAS_MCAUSE(0)) u_dut_b (
        .clock(clock), .reset(reset), .bus(bif),
        .env_violation(env_v[1]), .err_trap(trap_v[1]), .err_cause(cause_v[1]),
        .err_timeout(to_v[1]), .pending(pend_v[1]), .hit_count(hc_b)
    );

    int cfg_mode [2] = '{3, 1};
    int cfg_lat  [2] = '{4, 16};
    bit cfg_mc   [2] = '{1'b1, 1'b0};

    bit m_env [2];
    bit m_trap [2];
    bit m_cause [2];
    bit m_to [2];
    bit m_pend [2];
    int m_start [2];
    int m_hits [2];
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // region membership as an offset from the aligned base, modulo 2^32
    function automatic bit in_reg(input logic [31:0] a, input logic [31:0] base);
        logic [31:0] lo;
        logic [31:0] off;
        lo  = base - (base % 32'd4);
        off = a - lo;
        return off < 32'd4;
    endfunction

    task automatic model_step(input int d);
        bit rd_f, wr_f, fev, viol, touch, wr, hit, inb;
        logic [31:0] code;
        rd_f = (cfg_mode[d] & 1) != 0;
        wr_f = (cfg_mode[d] & 2) != 0;
        if (!reset) begin
            m_env[d] = 0; m_trap[d] = 0; m_cause[d] = 0; m_to[d] = 0; m_pend[d] = 0; m_hits[d] = 0;
        end else begin
            fev = 0; viol = 0; touch = 0; wr = 0;
            for (int k = 0; k < 4; k++) begin
                inb = in_reg(bif.rvfi_bus_addr + 32'(k), bif.dmem_addr);
                if (bif.rvfi_bus_valid[0] && bif.rvfi_bus_data[0] && inb &&
                    ((bif.rvfi_bus_rmask[k] && rd_f) || (bif.rvfi_bus_wmask[k] && wr_f))) begin
                    if (bif.rvfi_bus_fault[0]) fev = 1; else viol = 1;
                end
                inb = in_reg(bif.rvfi_mem_addr + 32'(k), bif.dmem_addr);
                if (inb && ((bif.rvfi_mem_rmask[k] && rd_f) || (bif.rvfi_mem_wmask[k] && wr_f))) touch = 1;
                if (inb && bif.rvfi_mem_wmask[k] && wr_f) wr = 1;
            end
            hit = bif.check && bif.rvfi_valid[0] && touch;
            if (hit) begin
                if (!bif.rvfi_trap[0]) m_trap[d] = 1;
                code = wr ? 32'd7 : 32'd5;
                if (cfg_mc[d] && (bif.rvfi_csr_mcause_wmask != 32'hFFFF_FFFF ||
                                  bif.rvfi_csr_mcause_wdata != code)) m_cause[d] = 1;
                if (m_hits[d] < 65535) m_hits[d]++;
            end
            if (viol) m_env[d] = 1;
            if (!m_to[d]) begin
                if (m_pend[d]) begin
                    if (hit) m_pend[d] = 0;
                    else if (cfg_lat[d] > 0 && (cyc - m_start[d]) >= cfg_lat[d]) begin
                        m_pend[d] = 0;
                        m_to[d]   = 1;
                    end
                end else if (fev && !hit) begin
                    m_pend[d]  = 1;
                    m_start[d] = cyc;
                end
            end
        end
    endtask

    task automatic compare(input int d);
        chk_eq($sformatf("env_%0d", d),   32'(env_v[d]),   32'(m_env[d]));
        chk_eq($sformatf("trap_%0d", d),  32'(trap_v[d]),  32'(m_trap[d]));
        chk_eq($sformatf("cause_%0d", d), 32'(cause_v[d]), 32'(m_cause[d]));
        chk_eq($sformatf("tmo_%0d", d),   32'(to_v[d]),    32'(m_to[d]));
        chk_eq($sformatf("pend_%0d", d),  32'(pend_v[d]),  32'(m_pend[d]));
        chk_eq($sformatf("hits_%0d", d),  32'((d == 0) ? hc_a : hc_b), 32'(m_hits[d]));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step(0);
        model_step(1);
        cyc++;
        #1;
        compare(0);
        compare(1);
    endtask

    task automatic idle();
        bif.check = 1'b1;
        bif.rvfi_valid = '0; bif.rvfi_trap = '0; bif.rvfi_mem_fault = '0;
        bif.rvfi_mem_addr = '0; bif.rvfi_mem_rmask = '0; bif.rvfi_mem_wmask = '0;
        bif.rvfi_csr_mcause_wmask = '0; bif.rvfi_csr_mcause_wdata = '0;
        bif.rvfi_bus_valid = '0; bif.rvfi_bus_data = '0; bif.rvfi_bus_fault = '0;
        bif.rvfi_bus_addr = '0; bif.rvfi_bus_rmask = '0; bif.rvfi_bus_wmask = '0;
    endtask

    task automatic bus_tx(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm, input logic f);
        idle();
        bif.rvfi_bus_valid = 1'b1; bif.rvfi_bus_data = 1'b1; bif.rvfi_bus_fault = f;
        bif.rvfi_bus_addr = a; bif.rvfi_bus_rmask = rm; bif.rvfi_bus_wmask = wm;
        tick();
        idle();
    endtask

    task automatic ret_tx(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                          input logic t, input logic [31:0] wd);
        idle();
        bif.rvfi_valid = 1'b1; bif.rvfi_trap = t; bif.rvfi_mem_addr = a;
        bif.rvfi_mem_rmask = rm; bif.rvfi_mem_wmask = wm;
        bif.rvfi_csr_mcause_wmask = 32'hFFFF_FFFF; bif.rvfi_csr_mcause_wdata = wd;
        tick();
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] base;
        idle();
        bif.dmem_addr = 32'h0000_0100;
        reset = 1'b0;
        tick();
        tick();
        chk_eq("rst_hits", 32'(hc_a), 32'd0);
        chk_eq("rst_pend", 32'(pend_v), 32'd0);
        reset = 1'b1;

        // load fault then trapping load two cycles later
        bus_tx(32'h0000_0100, 4'b1111, 4'b0000, 1'b1);
        chk_eq("t1_pend_on", 32'(pend_v), 32'd3);
        tick();
        ret_tx(32'h0000_0100, 4'b1111, 4'b0000, 1'b1, 32'd5);
        chk_eq("t1_pend_off", 32'(pend_v), 32'd0);
        chk_eq("t1_hits", 32'(hc_a), 32'd1);
        chk_eq("t1_errs", 32'({trap_v, cause_v, to_v, env_v}), 32'd0);

        // unfaulted store to the region
        bus_tx(32'h0000_0102, 4'b0000, 4'b0001, 1'b0);
        tick();
        chk_eq("t2_env", 32'(env_v), 32'd1);

        // store straddling the region base
        do_reset();
        ret_tx(32'h0000_00FE, 4'b0000, 4'b1100, 1'b0, 32'd7);
        chk_eq("t3_trap", 32'(trap_v), 32'd1);
        do_reset();
        ret_tx(32'h0000_00FE, 4'b0000, 4'b1100, 1'b1, 32'd5);
        chk_eq("t3_cause", 32'(cause_v[0]), 32'd1);
        chk_eq("t3_notrap", 32'(trap_v[0]), 32'd0);

        // timeout at MAX_LAT=4 on dut_a
        do_reset();
        bus_tx(32'h0000_0100, 4'b0001, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("t4_early", 32'(to_v[0]), 32'd0);
        end
        tick();
        chk_eq("t4_tmo", 32'(to_v[0]), 32'd1);
        chk_eq("t4_pend", 32'(pend_v), 32'd2);

        // reset aborts a wait at cnt=2
        do_reset();
        bus_tx(32'h0000_0100, 4'b0001, 4'b0000, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_eq("t5_clear", 32'({pend_v, to_v, hc_a}), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        ret_tx(32'h0000_0100, 4'b1111, 4'b0000, 1'b1, 32'd5);
        chk_eq("t5_no_tmo", 32'(to_v), 32'd0);

        // read-only fault mode on dut_b
        do_reset();
        bus_tx(32'h0000_0100, 4'b0000, 4'b0001, 1'b0);
        ret_tx(32'h0000_0100, 4'b0000, 4'b1111, 1'b0, 32'd7);
        chk_eq("t6_quiet", 32'({env_v[1], trap_v[1]}), 32'd0);
        ret_tx(32'h0000_0100, 4'b1111, 4'b0000, 1'b0, 32'd5);
        chk_eq("t6_trap", 32'(trap_v[1]), 32'd1);

        // region at the top of the address space with an access wrapping past zero
        do_reset();
        bif.dmem_addr = 32'hFFFF_FFFD;
        ret_tx(32'hFFFF_FFFE, 4'b1111, 4'b0000, 1'b0, 32'd5);
        chk_eq("wrap_trap", 32'(trap_v), 32'd3);
        do_reset();
        ret_tx(32'h0000_0000, 4'b1111, 4'b0000, 1'b0, 32'd5);
        chk_eq("wrap_out", 32'(trap_v), 32'd0);

        // randomized traffic around a few region bases
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                case ($urandom_range(0, 3))
                    0: bif.dmem_addr = 32'h0000_0100;
                    1: bif.dmem_addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
                    2: bif.dmem_addr = 32'h0000_0002;
                    default: bif.dmem_addr = $urandom;
                endcase
            end
            base = bif.dmem_addr;
            reset = ($urandom_range(0, 23) != 0);
            bif.check = ($urandom_range(0, 7) != 0);
            bif.rvfi_valid = 1'($urandom_range(0, 3) != 0);
            bif.rvfi_trap = 1'($urandom_range(0, 7) != 0);
            bif.rvfi_mem_fault = 1'($urandom);
            bif.rvfi_mem_addr = base + 32'($urandom_range(0, 11)) - 32'd6;
            bif.rvfi_mem_rmask = 4'($urandom);
            bif.rvfi_mem_wmask = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            bif.rvfi_csr_mcause_wmask = ($urandom_range(0, 7) != 0) ? 32'hFFFF_FFFF : $urandom;
            case ($urandom_range(0, 3))
                0: bif.rvfi_csr_mcause_wdata = 32'd5;
                1: bif.rvfi_csr_mcause_wdata = 32'd7;
                2: bif.rvfi_csr_mcause_wdata = bif.rvfi_mem_wmask != 4'd0 ? 32'd7 : 32'd5;
                default: bif.rvfi_csr_mcause_wdata = 32'($urandom_range(0, 15));
            endcase
            bif.rvfi_bus_valid = 1'($urandom_range(0, 3) == 0);
            bif.rvfi_bus_data = 1'($urandom_range(0, 3) != 0);
            bif.rvfi_bus_fault = 1'($urandom_range(0, 7) != 0);
            bif.rvfi_bus_addr = base + 32'($urandom_range(0, 11)) - 32'd6;
            bif.rvfi_bus_rmask = 4'($urandom);
            bif.rvfi_bus_wmask = 4'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
